// File: rtl/axis_frame_source.sv
// axis_frame_source: frame RAM written by a host and streamed out in raster order over AXI4-Stream.
// Optional macro FRAME_LOOP_EN adds loop_i so that frames repeat back-to-back with no gap.
module axis_frame_source #(
    parameter int unsigned MAX_DIM = 28,
    parameter int unsigned DATA_W  = 8
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic [$clog2(MAX_DIM+1)-1:0]         image_dimension,
    input  logic                                 wr_en_i,
    input  logic [$clog2(MAX_DIM*MAX_DIM)-1:0]   wr_addr_i,
    input  logic [DATA_W-1:0]                    wr_data_i,
    input  logic                                 start_i,
`ifdef FRAME_LOOP_EN
    input  logic                                 loop_i,
`endif
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic                                 err_o,
    output logic [DATA_W-1:0]                    m_axis_tdata,
    output logic                                 m_axis_tvalid,
    input  logic                                 m_axis_tready,
    output logic                                 m_axis_tlast
);

    localparam int unsigned DEPTH  = MAX_DIM * MAX_DIM;
    localparam int unsigned DIM_W  = $clog2(MAX_DIM + 1);
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic                w_busy_nxt;
    logic                w_done_nxt;
    logic                w_err_nxt;
    logic                w_start_ok;
    logic                w_flush;

    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic [CNT_W-1:0]    r_total;
    logic [CNT_W-1:0]    r_rd_idx;
    logic [CNT_W-1:0]    r_beat_cnt;

    // Two-entry output FIFO: head drives the AXI outputs, skid absorbs one stalled read.
    logic                r_out_valid;
    logic [DATA_W-1:0]   r_out_data;
    logic                r_out_last;
    logic                r_skid_valid;
    logic [DATA_W-1:0]   r_skid_data;
    logic                r_skid_last;

    logic                w_dim_ok;
    logic                w_wr_ok;
    logic                w_pop;
    logic                w_frame_end;
    logic [1:0]          w_fifo_cnt;
    logic                w_fifo_room;
    logic                w_rd_more;
    logic                w_rd_last;
    logic                w_rd_wrap;
    logic                w_issue;
    logic                w_loop;
    logic [ADDR_W-1:0]   w_rd_addr;

    assign w_dim_ok    = (image_dimension != '0) && (image_dimension <= DIM_W'(MAX_DIM));
    assign w_wr_ok     = wr_en_i && (r_state == S_IDLE) && (32'(wr_addr_i) < DEPTH);
    assign w_pop       = r_out_valid && m_axis_tready;
    assign w_frame_end = w_pop && (r_beat_cnt == r_total - CNT_W'(1));
    assign w_fifo_cnt  = {1'b0, r_out_valid} + {1'b0, r_skid_valid};
    assign w_fifo_room = (w_fifo_cnt < 2'd2);
    assign w_rd_last   = (r_rd_idx == r_total - CNT_W'(1));
    assign w_rd_addr   = ADDR_W'(r_rd_idx);

`ifdef FRAME_LOOP_EN
    // Reads run ahead across the frame boundary; a non-looping end flushes the prefetch.
    assign w_loop    = loop_i;
    assign w_rd_more = 1'b1;
    assign w_rd_wrap = w_rd_last;
`else
    assign w_loop    = 1'b0;
    assign w_rd_more = (r_rd_idx < r_total);
    assign w_rd_wrap = 1'b0;
`endif

    assign w_issue = (r_state == S_STREAM) && w_fifo_room && w_rd_more && !w_flush;

    // Next-state and registered-output values.
    always_comb begin
        w_state_nxt = r_state;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_err_nxt   = r_err;
        w_start_ok  = 1'b0;
        w_flush     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    if (w_dim_ok) begin
                        w_state_nxt = S_STREAM;
                        w_busy_nxt  = 1'b1;
                        w_start_ok  = 1'b1;
                    end else begin
                        w_err_nxt  = 1'b1;
                        w_done_nxt = 1'b1;
                    end
                end
            end
            S_STREAM: begin
                if (w_frame_end) begin
                    w_done_nxt = 1'b1;
                    if (!w_loop) begin
                        w_state_nxt = S_DONE;
                        w_busy_nxt  = 1'b0;
                        w_flush     = 1'b1;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Frame RAM write port; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (w_wr_ok) begin
            r_mem[wr_addr_i] <= wr_data_i;
        end
    end

    // Read counter, beat counter and output FIFO; RAM read data lands directly in a FIFO slot.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_total      <= '0;
            r_rd_idx     <= '0;
            r_beat_cnt   <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_last   <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_last  <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_total    <= CNT_W'(image_dimension) * CNT_W'(image_dimension);
                r_rd_idx   <= '0;
                r_beat_cnt <= '0;
            end
            if (w_issue) begin
                r_rd_idx <= w_rd_wrap ? '0 : r_rd_idx + CNT_W'(1);
            end
            if (w_pop) begin
                r_beat_cnt <= w_frame_end ? '0 : r_beat_cnt + CNT_W'(1);
            end

            if (w_flush) begin
                r_out_valid  <= 1'b0;
                r_out_last   <= 1'b0;
                r_skid_valid <= 1'b0;
            end else if (w_pop || !r_out_valid) begin
                if (r_skid_valid) begin
                    r_out_valid  <= 1'b1;
                    r_out_data   <= r_skid_data;
                    r_out_last   <= r_skid_last;
                    r_skid_valid <= 1'b0;
                end else begin
                    r_out_valid <= w_issue;
                    if (w_issue) begin
                        r_out_data <= r_mem[w_rd_addr];
                        r_out_last <= w_rd_last;
                    end else begin
                        r_out_last <= 1'b0;
                    end
                end
            end else if (w_issue) begin
                r_skid_valid <= 1'b1;
                r_skid_data  <= r_mem[w_rd_addr];
                r_skid_last  <= w_rd_last;
            end
        end
    end

    assign busy_o        = r_busy;
    assign done_o        = r_done;
    assign err_o         = r_err;
    assign m_axis_tdata  = r_out_data;
    assign m_axis_tvalid = r_out_valid;
    assign m_axis_tlast  = r_out_last;

endmodule

// File: doc/axis_frame_source.md
# axis_frame_source

Frame-buffered AXI4-Stream pixel transmitter that drives the CNN_AXIS slave input. A host writes one square grayscale image of up to MAX_DIM×MAX_DIM 8-bit pixels into an internal frame RAM. On a start pulse, the block streams the pixels in raster order with full tvalid/tready backpressure and asserts tlast on the final pixel. It is the hardware source at the upstream end of the convolution datapath's input stream.

## Interface
- MAX_DIM, 28, maximum image side length in pixels (MNIST)
- DATA_W, 8, pixel width in bits
- clk_i  in  1  single clock; all logic on the rising edge
- reset_i  in  1  synchronous, active-high reset
- image_dimension  in  $clog2(MAX_DIM+1)  image side N; sampled on an accepted start
- wr_en_i  in  1  frame RAM write strobe
- wr_addr_i  in  $clog2(MAX_DIM*MAX_DIM)  write address, raster index row*N+col
- wr_data_i  in  DATA_W  pixel to write
- start_i  in  1  single-cycle request to stream one frame
- busy_o  out  1  high from an accepted start until the last beat is accepted
- done_o  out  1  one-cycle pulse after the last beat or after an error abort
- err_o  out  1  sticky; set on a start with invalid dimension; cleared by reset only
- m_axis_tdata  out  DATA_W  pixel
- m_axis_tvalid  out  1  beat valid
- m_axis_tready  in  1  sink ready
- m_axis_tlast  out  1  high on beat N*N−1 only

## Operation
- Frame RAM: MAX_DIM*MAX_DIM × DATA_W, synchronous read, 1-cycle latency, one write port and one read port.
- Writes are accepted in IDLE only. Writes in STREAM are ignored, and RAM contents are unchanged. Out-of-range addresses (≥ MAX_DIM*MAX_DIM) are ignored.
- FSM states:
  - IDLE:
    - start_i with 1 ≤ image_dimension ≤ MAX_DIM: latch N, total = N*N, and go to STREAM.
    - start_i with an invalid dimension (0 or > MAX_DIM): set err_o, pulse done_o, stay in IDLE, emit no beats.
  - STREAM: the read counter issues RAM reads at raster index 0..total−1 into a 2-entry output FIFO. A read is issued only when the FIFO plus in-flight reads is < 2. The head of the FIFO drives m_axis_*.
  - DONE: entered when the beat with tlast is accepted (tvalid & tready). Pulses done_o for one cycle, then returns to IDLE.
- start_i outside IDLE is ignored.
- Beat counter: $clog2(MAX_DIM*MAX_DIM+1) bits, counts accepted beats. tlast = (beat count == total−1) for the head beat.
- AXI rules:
  - Once tvalid is high, tvalid, tdata and tlast hold stable until tready is seen.
  - tvalid never depends combinationally on tready.

## Timing
- Reset values: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, busy_o=0, done_o=0, err_o=0. FSM=IDLE, counters=0. Reset does not clear RAM contents.
- Start accepted at cycle 0: busy_o high at cycle 1; first tvalid at cycle 2.
- With tready held high: one beat per cycle with no bubbles. The last beat is at cycle 2+total−1; done_o pulses on the following cycle.
- tready low for k cycles: the stream stalls exactly k cycles. No beat is lost or duplicated.
- busy_o falls in the same cycle done_o rises.
- Reset mid-frame: tvalid drops on the cycle after reset is sampled; no tlast is produced. The next start streams from pixel 0.
- Write and start in the same IDLE cycle: the write lands, and the new pixel value is streamed.

## Configuration
- FRAME_LOOP_EN defined:
  - Adds input loop_i (1 bit).
  - If loop_i is high when the tlast beat is accepted, the block restarts at pixel 0 without leaving STREAM and without a gap; the next frame's first beat is on the next cycle.
  - done_o pulses on every frame end.
  - busy_o stays high.
- FRAME_LOOP_EN undefined: loop_i port is absent; each start produces exactly one frame.

## Test plan
- Write pixel i = i mod 256 for N=28, start, tready=1 -> 784 beats with tdata = 0,1,…,255,0,…; tlast only on beat 783; done_o at cycle 786.
- N=3, pixels 10..18, tready toggles 1,0,0,1,… -> beats 10..18 in order; tdata stable across stalls; tlast on 18.
- start with image_dimension=0, then 29 -> no tvalid; done_o pulses each time; err_o=1 and stays 1.
- N=4, reset_i asserted after 5 beats -> tvalid=0 next cycle; fresh start streams from pixel 0.
- Write to address 2 and start in the same IDLE cycle, N=2 -> third beat carries the new value. A write during STREAM is ignored and not reflected in the next frame.
- FRAME_LOOP_EN, N=2, loop_i=1 -> beats 0,1,2,3,0,1,… back-to-back; tlast every 4th beat; done_o pulse per frame.
